// File: rtl/demux_1x4.sv
// -----------------------------------------------------------------------------
// demux_1x4 : registered 1-to-4 demultiplexer.
//
// Routes data input `i` to the output selected by `s` (0..3 -> y0..y3).
// The three unselected outputs are driven to zero. All outputs come straight
// from flops, so each instance adds exactly one clock of latency. There is no
// combinational path from `i` or `s` to any output.
//
// Optional feature, enabled by defining DEMUX_1X4_SEL_FLAG_EN:
//   adds output `sel_oh`, a registered one-hot copy of the sampled select.
//   It lets downstream logic tell "selected with data 0" apart from
//   "not selected". When the macro is undefined, the port and its flops do
//   not exist, and y0..y3 behave identically in both builds.
//
// Cascading into a 1x8: the first stage takes s = {1'b0, s8[2]}. Its y0 feeds
// the low instance and its y1 feeds the high instance. The second stages use
// s8[1:0] delayed by one cycle, which keeps the select aligned with the data.
// The integrator supplies that delay. Total latency is 2 cycles.
// -----------------------------------------------------------------------------
module demux_1x4 #(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] i,
  input  logic [1:0]    s,
  output logic [DW-1:0] y3,
  output logic [DW-1:0] y2,
  output logic [DW-1:0] y1,
  output logic [DW-1:0] y0
`ifdef DEMUX_1X4_SEL_FLAG_EN
  ,
  output logic [3:0]    sel_oh
`endif
);

  // Next-state value for each output register.
  logic [DW-1:0] y0_nxt;
  logic [DW-1:0] y1_nxt;
  logic [DW-1:0] y2_nxt;
  logic [DW-1:0] y3_nxt;

  // Steer `i` to the selected output. Every other output is forced to zero.
  always_comb begin
    // NOTE: every output gets a default before the case statement. This means
    // no path can leave a signal unassigned, so no latch is inferred.
    y0_nxt = '0;
    y1_nxt = '0;
    y2_nxt = '0;
    y3_nxt = '0;
    unique case (s)
      2'd0:    y0_nxt = i;
      2'd1:    y1_nxt = i;
      2'd2:    y2_nxt = i;
      2'd3:    y3_nxt = i;
      default: ; // X/Z select: all outputs stay zero; no protection needed
    endcase
  end

  // Output registers. Asynchronous reset clears all outputs immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments. All four outputs
    // update together from values computed before the edge, so there is no
    // cycle in which two outputs carry data at once.
    if (!rst_n) begin
      y0 <= '0;
      y1 <= '0;
      y2 <= '0;
      y3 <= '0;
    end else begin
      y0 <= y0_nxt;
      y1 <= y1_nxt;
      y2 <= y2_nxt;
      y3 <= y3_nxt;
    end
  end

`ifdef DEMUX_1X4_SEL_FLAG_EN
  // One-hot decode of the select. It is registered alongside the data.
  logic [3:0] sel_oh_nxt;

  // Decode s into a one-hot flag vector.
  always_comb begin
    sel_oh_nxt = 4'b0000;
    unique case (s)
      2'd0:    sel_oh_nxt = 4'b0001;
      2'd1:    sel_oh_nxt = 4'b0010;
      2'd2:    sel_oh_nxt = 4'b0100;
      2'd3:    sel_oh_nxt = 4'b1000;
      default: ;
    endcase
  end

  // Flag register. It is zero only during reset and right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_oh <= 4'b0000;
    end else begin
      sel_oh <= sel_oh_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_demux_1x4.sv
// -----------------------------------------------------------------------------
// tb_demux_1x4 : directed self-checking bench for demux_1x4.
// Instances under test: a DW=1 instance, a DW=8 instance, and a 1x8 cascade
// built from three DW=1 instances. Set DEMUX_1X4_SEL_FLAG_EN to also check
// sel_oh.
// -----------------------------------------------------------------------------
module tb_demux_1x4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // ---------------- DW = 1 instance ----------------
  logic       i1;
  logic [1:0] s1;
  logic       a_y3, a_y2, a_y1, a_y0;
`ifdef DEMUX_1X4_SEL_FLAG_EN
  logic [3:0] a_sel_oh;
`endif

  demux_1x4 #(.DW(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i1),
    .s     (s1),
    .y3    (a_y3),
    .y2    (a_y2),
    .y1    (a_y1),
    .y0    (a_y0)
`ifdef DEMUX_1X4_SEL_FLAG_EN
    ,
    .sel_oh(a_sel_oh)
`endif
  );

  // ---------------- DW = 8 instance ----------------
  logic [7:0] i8;
  logic [1:0] s8;
  logic [7:0] b_y3, b_y2, b_y1, b_y0;
`ifdef DEMUX_1X4_SEL_FLAG_EN
  logic [3:0] b_sel_oh;
`endif

  demux_1x4 #(.DW(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i8),
    .s     (s8),
    .y3    (b_y3),
    .y2    (b_y2),
    .y1    (b_y1),
    .y0    (b_y0)
`ifdef DEMUX_1X4_SEL_FLAG_EN
    ,
    .sel_oh(b_sel_oh)
`endif
  );

  // ---------------- 1x8 cascade ----------------
  logic       ci;
  logic [2:0] sel8;
  logic [1:0] sel8_lo_d;   // second-stage select, delayed to line up with data
  logic       st_y3, st_y2, st_lo, st_hi;
  logic [7:0] cy;          // cascade outputs 7..0
`ifdef DEMUX_1X4_SEL_FLAG_EN
  logic [3:0] c_oh0, c_oh1, c_oh2;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel8_lo_d <= 2'd0;
    else        sel8_lo_d <= sel8[1:0];
  end

  demux_1x4 #(.DW(1)) u_stage1 (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (ci),
    .s     ({1'b0, sel8[2]}),
    .y3    (st_y3),
    .y2    (st_y2),
    .y1    (st_hi),
    .y0    (st_lo)
`ifdef DEMUX_1X4_SEL_FLAG_EN
    ,
    .sel_oh(c_oh0)
`endif
  );

  demux_1x4 #(.DW(1)) u_stage2_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (st_lo),
    .s     (sel8_lo_d),
    .y3    (cy[3]),
    .y2    (cy[2]),
    .y1    (cy[1]),
    .y0    (cy[0])
`ifdef DEMUX_1X4_SEL_FLAG_EN
    ,
    .sel_oh(c_oh1)
`endif
  );

  demux_1x4 #(.DW(1)) u_stage2_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (st_hi),
    .s     (sel8_lo_d),
    .y3    (cy[7]),
    .y2    (cy[6]),
    .y1    (cy[5]),
    .y0    (cy[4])
`ifdef DEMUX_1X4_SEL_FLAG_EN
    ,
    .sel_oh(c_oh2)
`endif
  );

  // Compare one observed value against the value the bench expects.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference values for the random phase.
  logic [7:0]  r_i;
  logic [1:0]  r_s;
  logic [31:0] r_exp;

  initial begin
    i1 = 1'b1; s1 = 2'd2;
    i8 = 8'h00; s8 = 2'd0;
    ci = 1'b0; sel8 = 3'd0;

    // Hold reset across 3 edges while the inputs say "route to y2".
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_y1x4", 32'({a_y3, a_y2, a_y1, a_y0}), 32'h0);
    check("reset_y8",   32'({b_y3, b_y2, b_y1, b_y0}), 32'h0);
    check("reset_casc", 32'(cy), 32'h0);
`ifdef DEMUX_1X4_SEL_FLAG_EN
    check("reset_sel_oh", 32'(a_sel_oh), 32'h0);
`endif

    // Release reset between edges. The first edge after release samples normally.
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep: i=1, s steps 0..3. Each output goes high one cycle later.
    i1 = 1'b1; s1 = 2'd0;
    tick();
    check("sweep_s0", 32'({a_y3, a_y2, a_y1, a_y0}), 32'b0001);
    s1 = 2'd1;
    tick();
    check("sweep_s1", 32'({a_y3, a_y2, a_y1, a_y0}), 32'b0010);
    s1 = 2'd2;
    tick();
    check("sweep_s2", 32'({a_y3, a_y2, a_y1, a_y0}), 32'b0100);
    s1 = 2'd3;
    tick();
    check("sweep_s3", 32'({a_y3, a_y2, a_y1, a_y0}), 32'b1000);
`ifdef DEMUX_1X4_SEL_FLAG_EN
    check("sweep_sel_oh", 32'(a_sel_oh), 32'b1000);
`endif

    // Zero data with s=3: every output is 0.
    i1 = 1'b0; s1 = 2'd3;
    tick();
    check("zero_data", 32'({a_y3, a_y2, a_y1, a_y0}), 32'b0000);
`ifdef DEMUX_1X4_SEL_FLAG_EN
    check("zero_sel_oh", 32'(a_sel_oh), 32'b1000);
`endif

    // Async reset mid-stream: y2 is high, then reset is asserted between edges.
    i1 = 1'b1; s1 = 2'd2;
    tick();
    check("pre_async_y2", 32'({a_y3, a_y2, a_y1, a_y0}), 32'b0100);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", 32'({a_y3, a_y2, a_y1, a_y0}), 32'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // DW=8: A5 routed to y1, the others are 0.
    i8 = 8'hA5; s8 = 2'd1;
    tick();
    check("w8_y1", 32'(b_y1), 32'hA5);
    check("w8_others", 32'({b_y3, b_y2, b_y0}), 32'h0);

    // 10 random vectors checked against a one-cycle-delayed reference model.
    for (int k = 0; k < 10; k++) begin
      r_i = 8'($urandom);
      r_s = 2'($urandom_range(0, 3));
      i8 = r_i; s8 = r_s;
      tick();
      r_exp = 32'(r_i) << (8 * int'(r_s));
      check($sformatf("rand_%0d", k), {b_y3, b_y2, b_y1, b_y0}, r_exp);
    end

    // 1x8 cascade: sel8=5, i=1. Only output 5 is high, after 2 cycles.
    ci = 1'b1; sel8 = 3'd5;
    tick();
    check("casc_1cycle", 32'(cy), 32'h00);
    tick();
    check("casc_2cycle", 32'(cy), 32'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1x4.md
Name: demux_1x4

Overview:
- Registered 1-to-4 demultiplexer: routes data input `i` to exactly one of four outputs (`y0`..`y3`), selected by the 2-bit select `s`.
- The three unselected outputs are driven to zero.
- Leaf building block, instantiated in pairs or trees to build wider demuxes (e.g. 1x8 from three 1x4 instances).
- Outputs are registered, so each instance adds exactly one clock of latency.

Parameters:
- DW, 1, data width of input `i` and of each output `y0`..`y3` (DW >= 1).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i  input  DW  data to be routed.
- s  input  2  select; s[1] is MSB; value 0..3 selects y0..y3.
- y3  output  DW  routed data when s==3, else 0.
- y2  output  DW  routed data when s==2, else 0.
- y1  output  DW  routed data when s==1, else 0.
- y0  output  DW  routed data when s==0, else 0.
- Positional port order is fixed as i, s, y3, y2, y1, y0. Clock and reset are listed ahead of these in the declaration and are connected by name.

Interface (already decided):
- One clock.
- Reset is asynchronous and active-low.
- Ports are named clk and rst_n.

Behaviour:
- Reset: while rst_n==0, y0..y3 are all 0. Reset assertion clears them immediately, independent of clk. Reset mid-operation discards any pending value.
- Release: on the first rising clk edge after rst_n returns to 1, the outputs sample normally. No extra warm-up cycle.
- Each rising clk edge with rst_n==1:
  - y[s] <= i.
  - Every other y <= 0 (all DW bits).
- Latency: exactly 1 cycle from the i/s change to the output. Outputs are stable between edges.
- No glitching on outputs: all four outputs come directly from flops, with no combinational path from i or s.
- Select changes: the new s takes effect at the next edge. The previously selected output returns to 0 at that same edge, so there is no overlap cycle where two outputs carry data.
- i==0 with any s: all outputs are 0. This is indistinguishable from "not selected" by design.
- Width: i is copied bit-for-bit. No sign extension or truncation (all widths are equal).
- Select containing X/Z: the output value is don't-care in simulation. Synthesis treats it as an undefined select; no protection logic is required.
- Cascading rule for a 1x8 built from three instances:
  - A first-stage instance is driven with s={1'b0, s8[2]}; its y0 feeds the low instance and its y1 feeds the high instance.
  - Second-stage instances use s8[1:0].
  - Total latency is 2 cycles. A cascade must delay the second-stage select by one cycle to keep it aligned with the data; this is the integrator's responsibility.

Optional Feature:
- Macro: DEMUX_1X4_SEL_FLAG_EN.
- Defined:
  - Adds output port `sel_oh`, output, width 4, placed after y0.
  - sel_oh is a registered one-hot of s: bit k is 1 when s==k was sampled at the last edge.
  - sel_oh updates on the same edge as y0..y3.
  - Reset value 4'b0000; it is 0 only during and immediately after reset.
  - Lets downstream logic distinguish "selected with data 0" from "not selected".
- Not defined: the port does not exist and the flag flops are not generated. Behaviour of y0..y3 is identical in both builds.

Test Plan:
- Reset: drive i=1, s=2, hold rst_n=0 across 3 edges -> y3..y0 = 0000. With the flag macro, sel_oh=0000.
- Sweep (DW=1): after reset release, i=1 with s stepping 0,1,2,3 on successive edges -> one cycle later y0..y3 go high one at a time (0001, 0010, 0100, 1000 as {y3,y2,y1,y0}).
- Zero data: i=0, s=3 -> all outputs 0 one cycle later. With the flag macro, sel_oh=1000.
- Async reset mid-stream: y2=1 held, assert rst_n=0 between clk edges -> y2 drops to 0 immediately, without waiting for an edge.
- Width and randomization: DW=8, i=8'hA5, s=1 -> y1=8'hA5 and y0=y2=y3=8'h00 after 1 edge. Follow with 10 random {i,s} vectors checked against a one-cycle-delayed reference model.
- 1x8 cascade: three instances with the delayed second-stage select, sel8=5, i=1 -> only output 5 is high, after 2 cycles.
